// File: rtl/fetch_pkg.sv
// Shared fetch constants, FSM state encoding and a saturating counter helper.
// Pure declarations: no timing or flow-control behaviour of its own.
package fetch_pkg;

  localparam int PC_W_DEF   = 8;
  localparam int INST_W_DEF = 9;
  localparam int BUF_DEPTH  = 2;
  localparam int BUF_PTR_W  = $clog2(BUF_DEPTH);
  localparam int BUF_CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int PERF_CNT_W = 16;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] val,
                                                   input logic                  en);
    if (en && (val != {PERF_CNT_W{1'b1}})) begin
      return val + PERF_CNT_W'(1);
    end
    return val;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order {pc, inst} FIFO; head is combinational, push lands next cycle.
// Flush overrides push and pop; a push into a full buffer without a pop is ignored.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [PC_W-1:0]      push_pc_i,
  input  logic [INST_W-1:0]    push_inst_i,
  input  logic                 pop_i,
  output logic                 head_vld_o,
  output logic [PC_W-1:0]      head_pc_o,
  output logic [INST_W-1:0]    head_inst_o,
  output logic [BUF_CNT_W-1:0] count_o
);

  logic [PC_W-1:0]      pc_mem_q   [BUF_DEPTH];
  logic [PC_W-1:0]      pc_mem_d   [BUF_DEPTH];
  logic [INST_W-1:0]    inst_mem_q [BUF_DEPTH];
  logic [INST_W-1:0]    inst_mem_d [BUF_DEPTH];
  logic [BUF_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUF_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [BUF_CNT_W-1:0] count_q, count_d;
  logic                 pop_eff;
  logic                 push_eff;

  always_comb begin
    pop_eff    = pop_i && (count_q != '0);
    push_eff   = push_i && ((count_q != BUF_CNT_W'(BUF_DEPTH)) || pop_eff);
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) begin
        pc_mem_d[wr_ptr_q]   = push_pc_i;
        inst_mem_d[wr_ptr_q] = push_inst_i;
        wr_ptr_d             = wr_ptr_q + BUF_PTR_W'(1);
      end
      if (pop_eff) begin
        rd_ptr_d = rd_ptr_q + BUF_PTR_W'(1);
      end
      count_d = count_q + BUF_CNT_W'(push_eff) - BUF_CNT_W'(pop_eff);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign head_vld_o  = (count_q != '0);
  assign head_pc_o   = pc_mem_q[rd_ptr_q];
  assign head_inst_o = inst_mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Sequential fetch into a 2-entry buffer; first instruction 2 cycles after issue, 1/cycle steady.
// Issue stalls when buffer + in-flight would exceed 2; FETCH_PERF_CNT_EN adds perf counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INST_W   = INST_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   pc_o,
  input  logic [INST_W-1:0] inst_i,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   inst_pc_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_target_i,
  input  logic              halt_i,
  output logic              halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_cnt_o,
  output logic [15:0]       redirect_cnt_o
`endif
);

  fetch_state_e         state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic                 inflight_q, inflight_d;
  logic [PC_W-1:0]      inflight_pc_q, inflight_pc_d;
  logic                 halted_q, halted_d;
`ifdef FETCH_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [PERF_CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
`endif

  logic                 pop;
  logic                 push;
  logic                 issue;
  logic                 idle;
  logic [2:0]           occupancy;
  logic [BUF_CNT_W-1:0] buf_count;

  fetch_buf #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_pc_i   (inflight_pc_q),
    .push_inst_i (inst_i),
    .pop_i       (pop),
    .head_vld_o  (inst_valid_o),
    .head_pc_o   (inst_pc_o),
    .head_inst_o (inst_o),
    .count_o     (buf_count)
  );

  always_comb begin
    pop       = inst_valid_o && inst_ready_i;
    // A response returning during a redirect belongs to the abandoned path.
    push      = inflight_q && !redirect_i;
    occupancy = 3'(buf_count) + 3'(inflight_q);
    idle      = (buf_count == '0) && !inflight_q;
    issue     = (state_q == RUN) && !halt_i && !redirect_i &&
                (occupancy < (3'd2 + 3'(pop)));

    state_d = state_q;
    case (state_q)
      RUN:     if (halt_i) state_d = DRAIN;
      DRAIN:   if (!halt_i) state_d = RUN;
               else if (idle) state_d = HALTED;
      HALTED:  if (!halt_i) state_d = RUN;
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALTED);

    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (redirect_i) begin
      pc_d = redirect_target_i;
    end else if (issue) begin
      pc_d          = pc_q + PC_W'(1);
      inflight_pc_d = pc_q;
    end

`ifdef FETCH_PERF_CNT_EN
    fetch_cnt_d    = sat_inc(fetch_cnt_q, pop);
    redirect_cnt_d = sat_inc(redirect_cnt_q, redirect_i);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      pc_q           <= RESET_PC;
      inflight_q     <= 1'b0;
      inflight_pc_q  <= '0;
      halted_q       <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
`endif
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      inflight_q     <= inflight_d;
      inflight_pc_q  <= inflight_pc_d;
      halted_q       <= halted_d;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
`endif
    end
  end

  assign pc_o     = pc_q;
  assign halted_o = halted_q;
`ifdef FETCH_PERF_CNT_EN
  assign fetch_cnt_o    = fetch_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule
